// File: rtl/dot_row_accumulator.sv
// Sums each group of ROW_LEN unsigned product beats into a row dot-product and
// buffers completed sums in a FWFT FIFO. Define DOT_ROW_ACC_SAT_EN to saturate instead of wrap.
module dot_row_accumulator #(
  parameter int DATA_W     = 8,
  parameter int ROW_LEN    = 8,
  parameter int ACC_W      = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_done,
  output logic              in_ready,
  output logic              sum_valid,
  output logic [ACC_W-1:0]  sum_data,
  output logic              sum_partial,
  input  logic              sum_ready,
  output logic [7:0]        row_count,
  output logic              overflow,
  output logic              all_done
);

  localparam int CNT_W = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ROW_LEN - 1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   elem_cnt, elem_cnt_nxt;
  logic [ACC_W-1:0]   acc_p0;
  logic [ACC_W-1:0]   acc_base;
  logic [ACC_W-1:0]   acc_sum;
  logic               add_ovf;
  logic               beat;
  logic               row_push;
  logic               part_push;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic [ACC_W-1:0]   push_data;
  logic [ACC_W-1:0]   fifo_data [FIFO_DEPTH];
  logic               fifo_part [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [OCC_W-1:0]   occ;

  // Returns {overflow, result}; the result either wraps or clamps at all-ones.
  function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    logic [ACC_W:0] wide;
    wide = {1'b0, a} + {{(ACC_W + 1 - DATA_W){1'b0}}, b};
`ifdef DOT_ROW_ACC_SAT_EN
    if (wide[ACC_W]) wide[ACC_W-1:0] = '1;
`endif
    return wide;
  endfunction

  assign fifo_full   = (occ == FULL_OCC);
  assign sum_valid   = (occ != '0);
  assign in_ready    = !fifo_full && ((state == IDLE) || (state == ACCUM));
  assign beat        = in_valid && in_ready;
  assign acc_base    = (elem_cnt == '0) ? '0 : acc_p0;
  assign {add_ovf, acc_sum} = acc_add(acc_base, in_data);
  assign row_push    = beat && (elem_cnt == LAST_IDX);
  assign part_push   = (state == DRAIN) && (elem_cnt != '0) && !fifo_full;
  assign push        = row_push || part_push;
  assign pop         = sum_valid && sum_ready;
  assign push_data   = row_push ? acc_sum : acc_p0;
  assign sum_data    = sum_valid ? fifo_data[rd_ptr] : '0;
  assign sum_partial = sum_valid ? fifo_part[rd_ptr] : 1'b0;
  assign all_done    = (state == DONE);

  always_comb begin
    state_nxt    = state;
    elem_cnt_nxt = elem_cnt;
    if (beat)
      elem_cnt_nxt = (elem_cnt == LAST_IDX) ? '0 : elem_cnt + CNT_W'(1);
    if (part_push)
      elem_cnt_nxt = '0;
    case (state)
      IDLE: begin
        if (beat)    state_nxt = ACCUM;
        if (in_done) state_nxt = DRAIN;
      end
      ACCUM: begin
        if (row_push) state_nxt = IDLE;
        if (in_done)  state_nxt = DRAIN;
      end
      DRAIN: begin
        if ((elem_cnt == '0) && (occ == '0)) state_nxt = DONE;
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      elem_cnt  <= '0;
      row_count <= '0;
      overflow  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
    end else begin
      state    <= state_nxt;
      elem_cnt <= elem_cnt_nxt;
      if (push)           row_count <= row_count + 8'd1;
      if (beat && add_ovf) overflow <= 1'b1;
      if (push)           wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)            rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Datapath registers: accumulator and sum storage carry no reset
  always_ff @(posedge clk) begin
    if (beat) acc_p0 <= acc_sum;
    if (push) begin
      fifo_data[wr_ptr] <= push_data;
      fifo_part[wr_ptr] <= part_push;
    end
  end

endmodule

// File: tb/tb_dot_row_accumulator.sv
// Directed bench for dot_row_accumulator with a scoreboard of expected row sums.
module tb_dot_row_accumulator;

  localparam int DATA_W     = 8;
  localparam int ROW_LEN    = 8;
  localparam int ACC_W      = 10;
  localparam int FIFO_DEPTH = 4;
  localparam int MAXV       = (1 << ACC_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_done;
  logic              in_ready;
  logic              sum_valid;
  logic [ACC_W-1:0]  sum_data;
  logic              sum_partial;
  logic              sum_ready;
  logic [7:0]        row_count;
  logic              overflow;
  logic              all_done;

  always #5 clk = ~clk;

  dot_row_accumulator #(
    .DATA_W(DATA_W), .ROW_LEN(ROW_LEN), .ACC_W(ACC_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_done(in_done), .in_ready(in_ready), .sum_valid(sum_valid),
    .sum_data(sum_data), .sum_partial(sum_partial), .sum_ready(sum_ready),
    .row_count(row_count), .overflow(overflow), .all_done(all_done)
  );

  typedef struct packed {
    logic             partial;
    logic [ACC_W-1:0] data;
  } entry_t;

  int     checks   = 0;
  int     failures = 0;
  entry_t sb[$];
  int     m_sum, m_cnt, m_rows;
  bit     m_run, m_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic entry_t fold(input int s, input bit part);
    entry_t e;
    e.partial = part;
`ifdef DOT_ROW_ACC_SAT_EN
    e.data = ACC_W'((s > MAXV) ? MAXV : s);
`else
    e.data = ACC_W'(s);
`endif
    return e;
  endfunction

  task automatic model_reset();
    sb.delete();
    m_sum  = 0;
    m_cnt  = 0;
    m_rows = 0;
    m_run  = 1'b1;
    m_ovf  = 1'b0;
  endtask

  // One clock: sample at negedge, advance the model, step past posedge.
  task automatic cycle();
    bit     exp_rdy;
    entry_t e;
    @(negedge clk);
    if (reset) begin
      model_reset();
    end else begin
      exp_rdy = m_run && (sb.size() < FIFO_DEPTH);
      check("in_ready", in_ready, exp_rdy);
      if (sum_valid && sum_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_sum_valid", sum_valid, 1'b0);
        end else begin
          e = sb.pop_front();
          check("sum_data", sum_data, e.data);
          check("sum_partial", sum_partial, e.partial);
        end
      end
      if (in_valid && exp_rdy) begin
        m_sum = ((m_cnt == 0) ? 0 : m_sum) + int'(in_data);
        m_cnt++;
        if (m_sum > MAXV) m_ovf = 1'b1;
        if (m_cnt == ROW_LEN) begin
          sb.push_back(fold(m_sum, 1'b0));
          m_cnt = 0;
          m_rows++;
        end
      end
      if (in_done && m_run) begin
        m_run = 1'b0;
        if (m_cnt != 0) begin
          sb.push_back(fold(m_sum, 1'b1));
          m_cnt = 0;
          m_rows++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic beats(input int n, input int val);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = DATA_W'(val);
      cycle();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_done = 1'b0; sum_ready = 1'b0;
    model_reset();
    cycle();
    cycle();
    reset = 1'b0;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_sum_valid", sum_valid, 1'b0);
    check("rst_sum_data", sum_data, 0);
    check("rst_sum_partial", sum_partial, 1'b0);
    check("rst_row_count", row_count, 0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_all_done", all_done, 1'b0);

    // Basic row of 8 x 10 = 80, visible one cycle after the last beat
    sum_ready = 1'b1;
    beats(8, 10);
    check("basic_latency_valid", sum_valid, 1'b1);
    check("basic_row_count", row_count, 32'(8'(m_rows)));
    cycle();
    cycle();

    // Overflow row: 8 x 255
    beats(8, 255);
    check("ovf_flag", overflow, 1'b1);
    check("ovf_model", overflow, m_ovf);
    cycle();
    cycle();
    check("ovf_drained", sum_valid, 1'b0);

    // Backpressure: four rows of 1s fill the FIFO
    sum_ready = 1'b0;
    beats(32, 1);
    check("bp_full_in_ready", in_ready, 1'b0);
    check("bp_full_valid", sum_valid, 1'b1);
    check("bp_row_count", row_count, 32'(8'(m_rows)));
    sum_ready = 1'b1;
    cycle();
    check("bp_ready_after_pop", in_ready, 1'b1);
    cycle();
    cycle();
    cycle();
    check("bp_empty", sum_valid, 1'b0);
    check("bp_sb_empty", sb.size(), 0);

    // Row completes on the same edge as a pop with two entries queued
    sum_ready = 1'b0;
    beats(8, 3);
    beats(8, 4);
    beats(7, 5);
    sum_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'd5;
    cycle();
    sum_ready = 1'b0;
    in_valid  = 1'b0;
    check("sim_valid", sum_valid, 1'b1);
    check("sim_row_count", row_count, 32'(8'(m_rows)));
    cycle();
    sum_ready = 1'b1;
    cycle();
    check("sim_second_left", sum_valid, 1'b1);
    cycle();
    check("sim_empty", sum_valid, 1'b0);

    // Partial final row: 5,5,5 with in_done on the third beat
    beats(2, 5);
    in_valid = 1'b1;
    in_data  = 8'd5;
    in_done  = 1'b1;
    cycle();
    in_valid = 1'b0;
    in_done  = 1'b0;
    check("part_not_done_yet", all_done, 1'b0);
    for (int i = 0; i < 20 && !all_done; i++) cycle();
    check("part_all_done", all_done, 1'b1);
    check("part_sb_empty", sb.size(), 0);
    check("part_row_count", row_count, 32'(8'(m_rows)));
    in_valid = 1'b1;
    in_data  = 8'd99;
    cycle();
    cycle();
    cycle();
    in_valid = 1'b0;
    check("late_row_count", row_count, 32'(8'(m_rows)));
    check("late_no_sum", sum_valid, 1'b0);
    check("late_all_done", all_done, 1'b1);

    // Reset out of DONE, then reset in the middle of a row
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("rst2_all_done", all_done, 1'b0);
    check("rst2_overflow", overflow, 1'b0);
    beats(5, 7);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    beats(8, 2);
    check("mid_row_count", row_count, 1);
    check("mid_overflow", overflow, 1'b0);
    check("mid_valid", sum_valid, 1'b1);
    cycle();
    cycle();
    check("mid_sb_empty", sb.size(), 0);
    check("mid_empty", sum_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
